fetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch stage for the 5-stage CPU.
- Decouples PC generation from decode with a DEPTH-entry prefetch queue.
- Issues back-to-back requests to a synchronous inst_rom with 1-cycle read latency. Handles exception and branch redirects by flushing the queue and squashing any in-flight fetch.
- Sits between the PC/redirect logic (exc_bus, jbr_bus) and the ID stage, which uses a valid/ready handshake.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues back-to-back inst_rom reads and buffers results in a DEPTH-entry queue toward ID.
// Optional macro FETCH_BYPASS_EN forwards returning data straight to out_bus when the queue is empty.
module fetch_queue #(
  parameter logic [31:0] START_ADDR = 32'hbfc00000,
  parameter int          DEPTH      = 4,
  parameter int          PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [32:0]      exc_bus,
  input  logic [32:0]      jbr_bus,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [64:0]      out_bus,
  output logic [PTR_W:0]   q_count,
  output logic [31:0]      IF_pc
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W + 2)'(DEPTH);

  logic [31:0]    pc;
  logic [31:0]    pc_d1;
  logic           inflight;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [64:0]    mem [DEPTH];

  logic           redirect;
  logic [31:0]    redirect_pc;
  logic [PTR_W+1:0] occ;
  logic [64:0]    ret_entry;
  logic           empty;
  logic           bypass;
  logic           push;
  logic           pop;

  assign redirect    = exc_bus[32] | jbr_bus[32];
  assign redirect_pc = exc_bus[32] ? exc_bus[31:0] : jbr_bus[31:0];

  // Counting the outstanding read guarantees a free slot for every returning instruction.
  assign occ      = {1'b0, count} + {{(PTR_W + 1){1'b0}}, inflight};
  assign inst_req = resetn & ~redirect & (occ < DEPTH_L);

  assign ret_entry = {inst, pc_d1[1:0] != 2'b00, pc_d1};
  assign empty     = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = empty & inflight;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;
  assign out_bus   = ~empty ? mem[rd_ptr] : (bypass ? ret_entry : '0);
  assign push      = inflight & ~(bypass & out_ready);
  assign pop       = ~empty & out_ready;

  assign inst_addr = pc;
  assign IF_pc     = pc;
  assign q_count   = count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc       <= START_ADDR;
      pc_d1    <= START_ADDR;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Flush and drop whatever returns next cycle.
      pc       <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= inst_req;
      if (inst_req) begin
        pc    <= {pc[31:2] + 30'd1, pc[1:0]};
        pc_d1 <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !redirect && push) mem[wr_ptr] <= ret_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of expected fetch stream checked at every ID handshake.
module tb_fetch_queue;

  localparam logic [31:0] START = 32'hbfc00000;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [32:0] exc_bus;
  logic [32:0] jbr_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_bus;
  logic [2:0]  q_count;
  logic [31:0] IF_pc;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic [31:0] exp_q [$];

  fetch_queue dut (
    .clk(clk), .resetn(resetn), .exc_bus(exc_bus), .jbr_bus(jbr_bus),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
    .q_count(q_count), .IF_pc(IF_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) if (inst_req) inst <= rom_f(inst_addr);

  // Scoreboard: every accepted head must be the next address of the current stream.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [31:0] e;
      logic [64:0] want;
      total++;
      n_acc++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got %h want nothing", out_bus);
      end else begin
        e = exp_q.pop_front();
        want = {rom_f(e), e[1:0] != 2'b00, e};
        if (out_bus !== want) begin
          bad++;
          $display("FAIL stream_entry: got %h want %h", out_bus, want);
        end
      end
    end
  end

  task automatic refill(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = {a[31:2] + 30'd1, a[1:0]};
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    resetn = 1'b0; out_ready = rdy; exc_bus = '0; jbr_bus = '0;
    @(negedge clk); #1;
    refill(START);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (IF_pc !== START) begin bad++; $display("FAIL reset_pc: got %h want %h", IF_pc, START); end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", q_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_bus !== 65'd0) begin bad++; $display("FAIL reset_bus: got %h want 0", out_bus); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", inst_req); end
  endtask

  task automatic test_stream;
    int base;
    do_reset(1'b1);
    base = n_acc;
    @(negedge clk);
    total++; if (inst_req !== 1'b1 || inst_addr !== START) begin bad++; $display("FAIL stream_c0_addr: got %b/%h want 1/%h", inst_req, inst_addr, START); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_c0_valid: got %b want 0", out_valid); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (inst_addr !== START + 32'd4) begin bad++; $display("FAIL stream_c1_addr: got %h want %h", inst_addr, START + 32'd4); end
    total++; if (out_valid !== 1'(BYP)) begin bad++; $display("FAIL stream_c1_valid: got %b want %0d", out_valid, BYP); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (out_valid !== 1'b1 || inst_addr !== START + 32'd8) begin bad++; $display("FAIL stream_c2: got %b/%h want 1/%h", out_valid, inst_addr, START + 32'd8); end
    repeat (15) begin @(posedge clk); #1; @(negedge clk); end
    #1;
    total++; if (n_acc - base !== 16 + BYP) begin bad++; $display("FAIL stream_rate: got %0d want %0d", n_acc - base, 16 + BYP); end
  endtask

  task automatic test_backpressure;
    int base;
    do_reset(1'b0);
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (q_count !== 3'd4) begin bad++; $display("FAIL bp_count: got %0d want 4", q_count); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", inst_req); end
    total++; if (IF_pc !== START + 32'h10) begin bad++; $display("FAIL bp_pc: got %h want %h", IF_pc, START + 32'h10); end
    total++; if (out_valid !== 1'b1 || out_bus !== {rom_f(START), 1'b0, START}) begin bad++; $display("FAIL bp_head: got %b/%h want 1/%h", out_valid, out_bus, {rom_f(START), 1'b0, START}); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = n_acc;
    @(negedge clk);
    repeat (11) begin @(posedge clk); #1; @(negedge clk); end
    #1;
    total++; if (n_acc - base !== 12) begin bad++; $display("FAIL bp_drain: got %0d want 12", n_acc - base); end
  endtask

  task automatic test_redirect_flush;
    int base;
    do_reset(1'b0);
    repeat (4) begin @(posedge clk); #1; end
    jbr_bus = {1'b1, 32'hbfc00100};
    @(negedge clk);
    total++; if (q_count !== 3'd3) begin bad++; $display("FAIL jbr_pre_count: got %0d want 3", q_count); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL jbr_req: got %b want 0", inst_req); end
    #1; refill(32'hbfc00100);
    @(posedge clk); #1;
    jbr_bus = '0; out_ready = 1'b1;
    base = n_acc;
    @(negedge clk);
    total++; if (q_count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL jbr_flush: got %0d/%b want 0/0", q_count, out_valid); end
    total++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00100) begin bad++; $display("FAIL jbr_addr: got %b/%h want 1/bfc00100", inst_req, inst_addr); end
    repeat (9) begin @(posedge clk); #1; @(negedge clk); end
    #1;
    total++; if (n_acc - base !== 8 + BYP) begin bad++; $display("FAIL jbr_count: got %0d want %0d", n_acc - base, 8 + BYP); end
  endtask

  task automatic test_exc_priority;
    @(posedge clk); #1;
    exc_bus = {1'b1, 32'hbfc00380};
    jbr_bus = {1'b1, 32'hbfc00100};
    @(negedge clk);
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL exc_req: got %b want 0", inst_req); end
    #1; refill(32'hbfc00380);
    @(posedge clk); #1;
    exc_bus = '0; jbr_bus = '0;
    @(negedge clk);
    total++; if (inst_addr !== 32'hbfc00380) begin bad++; $display("FAIL exc_addr: got %h want bfc00380", inst_addr); end
    repeat (6) begin @(posedge clk); #1; @(negedge clk); end
  endtask

  task automatic test_misaligned;
    int lat;
    @(posedge clk); #1;
    jbr_bus = {1'b1, 32'hbfc00102};
    @(negedge clk); #1;
    refill(32'hbfc00102);
    @(posedge clk); #1;
    jbr_bus = '0;
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = i; break; end
      @(posedge clk); #1;
    end
    total++; if (lat !== 2 - BYP) begin bad++; $display("FAIL mis_latency: got %0d want %0d", lat, 2 - BYP); end
    total++; if (out_bus[32:0] !== {1'b1, 32'hbfc00102}) begin bad++; $display("FAIL mis_first: got %h want 1_bfc00102", out_bus[32:0]); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_bus[32:0] !== {1'b1, 32'hbfc00106}) begin bad++; $display("FAIL mis_second: got %b/%h want 1/1_bfc00106", out_valid, out_bus[32:0]); end
    total++; if (IF_pc[1:0] !== 2'b10) begin bad++; $display("FAIL mis_pc_low: got %b want 10", IF_pc[1:0]); end
    repeat (4) begin @(posedge clk); #1; @(negedge clk); end
  endtask

  task automatic test_reset_midop;
    int base;
    do_reset(1'b0);
    repeat (4) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(negedge clk);
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req: got %b want 0", inst_req); end
    #1; refill(START);
    @(posedge clk); #1;
    resetn = 1'b1; out_ready = 1'b1;
    base = n_acc;
    @(negedge clk);
    total++; if (q_count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_flush: got %0d/%b want 0/0", q_count, out_valid); end
    total++; if (inst_req !== 1'b1 || inst_addr !== START) begin bad++; $display("FAIL rst_mid_addr: got %b/%h want 1/%h", inst_req, inst_addr, START); end
    repeat (6) begin @(posedge clk); #1; @(negedge clk); end
    #1;
    total++; if (n_acc - base !== 5 + BYP) begin bad++; $display("FAIL rst_mid_count: got %0d want %0d", n_acc - base, 5 + BYP); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    out_ready = 1'b0;
    exc_bus   = '0;
    jbr_bus   = '0;
    inst      = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_exc_priority();
    test_misaligned();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
